// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with almost-full/empty decodes, sticky error flags
// and a selectable registered or first-word-fall-through read port.
module param_sync_fifo #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic                     clk,
   input  logic                     rest,
   input  logic                     w_inc,
   input  logic [WIDTH-1:0]         w_data,
   output logic                     w_full,
   output logic                     w_afull,
   input  logic                     r_inc,
   output logic [WIDTH-1:0]         r_data,
   output logic                     r_valid,
   output logic                     r_empty,
   output logic                     r_aempty,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     clr_err,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
   localparam logic [AW-1:0] ONE_PTR = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // Status flags decode straight from the registered occupancy.
   assign w_full   = (count == FULL_CNT);
   assign w_afull  = (count >= AF_CNT);
   assign r_empty  = (count == '0);
   assign r_aempty = (count <= AE_CNT);

   assign wr_en = w_inc & ~w_full;
   assign rd_en = r_inc & ~r_empty;

   always_ff @(posedge clk) begin
      if (rest) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ONE_PTR;
         if (rd_en) rd_ptr <= rd_ptr + ONE_PTR;
         case ({wr_en, rd_en})
            2'b10:   count <= count + ONE_CNT;
            2'b01:   count <= count - ONE_CNT;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only accepted writes outside reset touch it.
   always_ff @(posedge clk) begin
      if (wr_en && !rest) mem[wr_ptr] <= w_data;
   end

   // A flag set in the same cycle as clr_err takes precedence over the clear.
   always_ff @(posedge clk) begin
      if (rest) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_inc && w_full) overflow <= 1'b1;
         else if (clr_err)    overflow <= 1'b0;
         if (r_inc && r_empty) underflow <= 1'b1;
         else if (clr_err)     underflow <= 1'b0;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign r_data  = mem[rd_ptr];
         assign r_valid = ~r_empty;
      end else begin : g_reg
         logic [WIDTH-1:0] rd_data_p1;
         logic             vld_p1;

         // Read stage: head word captured on the accepting edge, valid for one cycle.
         always_ff @(posedge clk) begin
            if (rest) begin
               rd_data_p1 <= '0;
               vld_p1     <= 1'b0;
            end else begin
               vld_p1 <= rd_en;
               if (rd_en) rd_data_p1 <= mem[rd_ptr];
            end
         end

         assign r_data  = rd_data_p1;
         assign r_valid = vld_p1;
      end
   endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: registered-read and FWFT instances driven in lockstep,
// compared every cycle against a queue-based model of the FIFO behaviour.
module tb_param_sync_fifo;

   localparam int W = 8;
   localparam int D = 16;

   logic         clk = 1'b0;
   logic         rest, w_inc, r_inc, clr_err;
   logic [W-1:0] w_data;

   logic [W-1:0] r_data0, r_data1;
   logic         r_valid0, r_valid1;
   logic         w_full0, w_full1, w_afull0, w_afull1;
   logic         r_empty0, r_empty1, r_aempty0, r_aempty1;
   logic [4:0]   count0, count1;
   logic         ovf0, ovf1, unf0, unf1;

   int total  = 0;
   int passed = 0;

   // Reference state
   logic [W-1:0] q[$];
   logic         m_ovf, m_unf;
   logic [W-1:0] m_rdata;
   logic         m_rvalid;

   always #5 clk = ~clk;

   param_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_dut0 (
      .clk(clk), .rest(rest), .w_inc(w_inc), .w_data(w_data),
      .w_full(w_full0), .w_afull(w_afull0), .r_inc(r_inc),
      .r_data(r_data0), .r_valid(r_valid0), .r_empty(r_empty0),
      .r_aempty(r_aempty0), .count(count0), .clr_err(clr_err),
      .overflow(ovf0), .underflow(unf0)
   );

   param_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_dut1 (
      .clk(clk), .rest(rest), .w_inc(w_inc), .w_data(w_data),
      .w_full(w_full1), .w_afull(w_afull1), .r_inc(r_inc),
      .r_data(r_data1), .r_valid(r_valid1), .r_empty(r_empty1),
      .r_aempty(r_aempty1), .count(count1), .clr_err(clr_err),
      .overflow(ovf1), .underflow(unf1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all();
      int n = q.size();
      chk("count0",    64'(count0),    64'(n));
      chk("count1",    64'(count1),    64'(n));
      chk("w_full",    64'(w_full0),   64'(n == D));
      chk("w_afull",   64'(w_afull0),  64'(n >= D - 2));
      chk("r_empty",   64'(r_empty0),  64'(n == 0));
      chk("r_aempty",  64'(r_aempty0), 64'(n <= 2));
      chk("flags1",    64'({w_full1, w_afull1, r_empty1, r_aempty1}),
          64'({n == D, n >= D - 2, n == 0, n <= 2}));
      chk("overflow",  64'({ovf1, ovf0}), 64'({m_ovf, m_ovf}));
      chk("underflow", 64'({unf1, unf0}), 64'({m_unf, m_unf}));
      chk("r_valid0",  64'(r_valid0),  64'(m_rvalid));
      chk("r_data0",   64'(r_data0),   64'(m_rdata));
      chk("r_valid1",  64'(r_valid1),  64'(n != 0));
      if (n != 0) chk("r_data1", 64'(r_data1), 64'(q[0]));
   endtask

   // One clock: apply inputs, advance the model with pre-edge occupancy, then compare.
   task automatic cycle(input logic wi, input logic [W-1:0] wd, input logic ri,
                        input logic ce, input logic rs);
      logic full, empty, wa, ra;
      w_inc = wi; w_data = wd; r_inc = ri; clr_err = ce; rest = rs;
      @(posedge clk);
      if (rs) begin
         q.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
      end else begin
         full  = (q.size() == D);
         empty = (q.size() == 0);
         wa = wi && !full;
         ra = ri && !empty;
         m_rvalid = ra;
         if (ra) m_rdata = q.pop_front();
         if (wa) q.push_back(wd);
         if (wi && full) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
         if (ri && empty) m_unf = 1'b1; else if (ce) m_unf = 1'b0;
      end
      #1;
      check_all();
   endtask

   initial begin
      rest = 1'b1; w_inc = 1'b0; r_inc = 1'b0; clr_err = 1'b0; w_data = '0;
      m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0; m_rvalid = 1'b0;

      cycle(0, 8'h00, 0, 0, 1);
      cycle(0, 8'h00, 0, 0, 0);

      // Fill 0x01..0x10, then one write too many
      for (int i = 1; i <= D; i++) begin
         cycle(1, 8'(i), 0, 0, 0);
         if (i == 13) chk("afull_13", 64'(w_afull0), 64'(0));
         if (i == 14) chk("afull_14", 64'(w_afull0), 64'(1));
         if (i == 15) chk("full_15",  64'(w_full0),  64'(0));
      end
      chk("full_16", 64'(w_full0), 64'(1));
      cycle(1, 8'hEE, 0, 0, 0);
      chk("ovf_17", 64'(ovf0), 64'(1));
      for (int i = 1; i <= D; i++) begin
         cycle(0, 8'h00, 1, 0, 0);
         chk("drain_data", 64'(r_data0), 64'(i));
      end
      cycle(0, 8'h00, 0, 1, 0);

      // Single word through the registered read
      cycle(1, 8'hA5, 0, 0, 0);
      chk("fwft_head", 64'(r_data1), 64'(8'hA5));
      cycle(0, 8'h00, 1, 0, 0);
      chk("rd_a5", 64'({r_valid0, r_data0}), 64'({1'b1, 8'hA5}));
      cycle(0, 8'h00, 0, 0, 0);
      chk("valid_pulse", 64'(r_valid0), 64'(0));
      cycle(1, 8'h3C, 0, 0, 0);
      chk("fwft_3c", 64'({r_valid1, r_data1}), 64'({1'b1, 8'h3C}));
      cycle(0, 8'h00, 1, 0, 0);

      // Simultaneous access at full and at empty
      for (int i = 0; i < D; i++) cycle(1, 8'($urandom), 0, 0, 0);
      cycle(1, 8'h77, 1, 0, 0);
      chk("full_both", 64'({count0, ovf0}), 64'({5'd15, 1'b1}));
      for (int i = 0; i < D - 1; i++) cycle(0, 8'h00, 1, 0, 0);
      cycle(1, 8'h99, 1, 0, 0);
      chk("empty_both", 64'({count0, unf0}), 64'({5'd1, 1'b1}));
      cycle(0, 8'h00, 1, 1, 0);

      // Steady streaming at half-full across pointer wrap
      for (int i = 0; i < 8; i++) cycle(1, 8'($urandom), 0, 0, 0);
      for (int i = 0; i < 40; i++) cycle(1, 8'($urandom), 1, 0, 0);
      chk("stream_cnt", 64'({count0, ovf0, unf0}), 64'({5'd8, 2'b00}));
      for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0, 0);

      // Mid-operation reset with count 5 and overflow set
      for (int i = 0; i < D; i++) cycle(1, 8'($urandom), 0, 0, 0);
      cycle(1, 8'h55, 0, 0, 0);
      for (int i = 0; i < D - 5; i++) cycle(0, 8'h00, 1, 0, 0);
      chk("pre_reset", 64'({count0, ovf0}), 64'({5'd5, 1'b1}));
      cycle(1, 8'h42, 1, 1, 1);
      chk("post_reset", 64'({count0, ovf0, r_valid0, r_data0, r_empty0, r_aempty0}),
          64'({5'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1}));
      cycle(0, 8'h00, 1, 1, 0);
      chk("unf_beats_clr", 64'(unf0), 64'(1));
      cycle(0, 8'h00, 0, 1, 0);

      // Random traffic with occasional clears and resets
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 79) == 0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
